// File: rtl/eva_intr_collector.sv
// Interrupt collector: per-channel edge/level triggering with masking, timestamped
// event FIFO drained by valid/ready, and coalescing of triggers while the FIFO is full.
module eva_intr_collector #(
    parameter int NUM_INTR   = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 32,
    parameter int OVF_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_INTR-1:0] intr_in,
    input  logic [NUM_INTR-1:0] intr_mask,
    input  logic [NUM_INTR-1:0] intr_level,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [NUM_INTR-1:0] evt_vec,
    output logic [TS_W-1:0]     evt_tick,
    output logic                evt_merged,
    output logic [OVF_W-1:0]    ovf_cnt,
    output logic                coal_pend
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [TS_W-1:0]     r_tick;
    logic [NUM_INTR-1:0] r_intr_ff;
    logic [NUM_INTR-1:0] r_in_svc;
    logic [NUM_INTR-1:0] r_coal;
    logic [OVF_W-1:0]    r_ovf_cnt;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [NUM_INTR-1:0] r_mem_vec    [FIFO_DEPTH];
    logic [TS_W-1:0]     r_mem_tick   [FIFO_DEPTH];
    logic                r_mem_merged [FIFO_DEPTH];

    logic [NUM_INTR-1:0] w_trig;
    logic [NUM_INTR-1:0] w_new;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_coalesce;

    // Level channels re-arm only after the line drops, edge channels after a low sample.
    generate
        for (genvar gi = 0; gi < NUM_INTR; gi++) begin : g_trig
            assign w_trig[gi] = intr_mask[gi] & intr_in[gi] &
                                (intr_level[gi] ? ~r_in_svc[gi] : ~r_intr_ff[gi]);
        end
    endgenerate

    assign w_new      = w_trig | r_coal;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop      = ~w_empty & evt_ready;
    assign w_push     = (|w_new) & (~w_full | w_pop);
    assign w_coalesce = (|w_new) & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= '0;
            r_intr_ff <= '0;
            r_in_svc  <= '0;
            r_coal    <= '0;
            r_ovf_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_tick    <= r_tick + TS_W'(1);
            r_intr_ff <= intr_in;
            r_in_svc  <= (r_in_svc | w_trig) & intr_in;
            if (w_push) begin
                r_coal   <= '0;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else if (w_coalesce) begin
                r_coal <= r_coal | w_trig;
                if ((|w_trig) && (r_ovf_cnt != '1)) begin
                    r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; outputs are gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_vec[r_wr_ptr]    <= w_new;
            r_mem_tick[r_wr_ptr]   <= r_tick;
            r_mem_merged[r_wr_ptr] <= (r_coal != '0);
        end
    end

    assign evt_valid  = ~w_empty;
    assign evt_vec    = w_empty ? '0 : r_mem_vec[r_rd_ptr];
    assign evt_tick   = w_empty ? '0 : r_mem_tick[r_rd_ptr];
    assign evt_merged = w_empty ? 1'b0 : r_mem_merged[r_rd_ptr];
    assign ovf_cnt    = r_ovf_cnt;
    assign coal_pend  = (r_coal != '0);

endmodule

// File: tb/tb_eva_intr_collector.sv
// Randomised and directed bench for eva_intr_collector: a behavioural model queues expected
// events, and a negedge monitor compares every handshake and status output against it.
module tb_eva_intr_collector;

    localparam int N  = 32;
    localparam int D  = 4;
    localparam int TW = 32;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  intr_in = '0;
    logic [N-1:0]  intr_mask = '0;
    logic [N-1:0]  intr_level = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [N-1:0]  evt_vec;
    logic [TW-1:0] evt_tick;
    logic          evt_merged;
    logic [OW-1:0] ovf_cnt;
    logic          coal_pend;

    always #5 clk = ~clk;

    eva_intr_collector #(.NUM_INTR(N), .FIFO_DEPTH(D), .TS_W(TW), .OVF_W(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .intr_in   (intr_in),
        .intr_mask (intr_mask),
        .intr_level(intr_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_vec   (evt_vec),
        .evt_tick  (evt_tick),
        .evt_merged(evt_merged),
        .ovf_cnt   (ovf_cnt),
        .coal_pend (coal_pend)
    );

    typedef struct {
        logic [N-1:0]  vec;
        logic [TW-1:0] tick;
        logic          merged;
    } evt_t;

    evt_t sb[$];
    evt_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    // Reference model: previous input sample, per-channel "serviced" flags, coalesced bits.
    logic [N-1:0]  m_prev, m_svc, m_coal;
    logic [TW-1:0] m_tick;
    logic [OW-1:0] m_ovf;
    int            m_occ;

    bit            exp_valid;
    logic [OW-1:0] exp_ovf;
    bit            exp_coal;
    bit            cur_rst = 1'b1;
    bit            chk_en  = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of inputs, advance the model for that cycle, then move past the edge.
    task automatic step(input logic [N-1:0] in, input logic [N-1:0] mask,
                        input logic [N-1:0] lvl, input logic rdy, input logic r);
        logic [N-1:0] trig;
        logic [N-1:0] nw;
        bit           pop;
        bit           has_space;
        evt_t         e;
        intr_in    = in;
        intr_mask  = mask;
        intr_level = lvl;
        evt_ready  = rdy;
        rst        = r;
        cur_rst    = r;
        exp_valid  = (m_occ > 0);
        exp_ovf    = m_ovf;
        exp_coal   = (m_coal != '0);
        if (r) begin
            m_prev = '0; m_svc = '0; m_coal = '0; m_tick = '0; m_ovf = '0; m_occ = 0;
            sb.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (lvl[i]) trig[i] = mask[i] && in[i] && !m_svc[i];
                else        trig[i] = mask[i] && in[i] && !m_prev[i];
            end
            nw        = trig | m_coal;
            pop       = rdy && (m_occ > 0);
            has_space = (m_occ < D) || pop;
            if (nw != '0 && has_space) begin
                e.vec = nw; e.tick = m_tick; e.merged = (m_coal != '0);
                sb.push_back(e);
                m_coal = '0;
                m_occ++;
            end else if (nw != '0) begin
                m_coal = m_coal | trig;
                if (trig != '0 && m_ovf != {OW{1'b1}}) m_ovf++;
            end
            if (pop) m_occ--;
            for (int i = 0; i < N; i++) begin
                if (!in[i])      m_svc[i] = 1'b0;
                else if (trig[i]) m_svc[i] = 1'b1;
            end
            m_prev = in;
            m_tick = m_tick + 1;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en && !cur_rst) begin
            chk("evt_valid", 64'(evt_valid), 64'(exp_valid));
            chk("ovf_cnt", 64'(ovf_cnt), 64'(exp_ovf));
            chk("coal_pend", 64'(coal_pend), 64'(exp_coal));
            if (evt_valid && evt_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got vec 0x%0h expected no event", evt_vec);
                end else begin
                    mon_e = sb.pop_front();
                    chk("evt_vec", 64'(evt_vec), 64'(mon_e.vec));
                    chk("evt_tick", 64'(evt_tick), 64'(mon_e.tick));
                    chk("evt_merged", 64'(evt_merged), 64'(mon_e.merged));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    localparam logic [N-1:0] ALL = '1;

    initial begin
        int p0;
        logic [N-1:0] rin, rmask, rlvl;
        int rdy_pct;
        @(posedge clk); #1;
        chk_en = 1'b1;
        step('0, '0, '0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b1);

        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_vec", 64'(evt_vec), 64'd0);
        chk("rst_tick", 64'(evt_tick), 64'd0);
        chk("rst_merged", 64'(evt_merged), 64'd0);
        chk("rst_ovf", 64'(ovf_cnt), 64'd0);
        chk("rst_coal", 64'(coal_pend), 64'd0);

        // Edge rise of 0x5 at tick 10, then held high.
        p0 = pops;
        for (int i = 0; i < 10; i++) step('0, ALL, '0, 1'b1, 1'b0);
        step(32'h5, ALL, '0, 1'b1, 1'b0);
        chk("edge_valid", 64'(evt_valid), 64'd1);
        chk("edge_vec", 64'(evt_vec), 64'h5);
        chk("edge_tick", 64'(evt_tick), 64'd10);
        for (int i = 0; i < 10; i++) step(32'h5, ALL, '0, 1'b1, 1'b0);
        chk("edge_count", 64'(pops - p0), 64'd1);

        // Level ch3: high 20, low 1, high again.
        step('0, ALL, 32'h8, 1'b1, 1'b0);
        p0 = pops;
        for (int i = 0; i < 20; i++) step(32'h8, ALL, 32'h8, 1'b1, 1'b0);
        step('0, ALL, 32'h8, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(32'h8, ALL, 32'h8, 1'b1, 1'b0);
        step('0, ALL, 32'h8, 1'b1, 1'b0);
        chk("level_count", 64'(pops - p0), 64'd2);

        // Masked ch0 with simultaneous ch0/ch1 rise.
        p0 = pops;
        step('0, 32'hFFFF_FFFE, '0, 1'b1, 1'b0);
        step(32'h3, 32'hFFFF_FFFE, '0, 1'b1, 1'b0);
        chk("mask_vec", 64'(evt_vec), 64'h2);
        for (int i = 0; i < 3; i++) step('0, 32'hFFFF_FFFE, '0, 1'b1, 1'b0);
        chk("mask_count", 64'(pops - p0), 64'd1);

        // Overflow: six rises into a 4-deep FIFO with the consumer stalled.
        step('0, ALL, '0, 1'b0, 1'b1);
        rin = '0;
        for (int i = 0; i < 6; i++) begin
            rin[i] = 1'b1;
            step(rin, ALL, '0, 1'b0, 1'b0);
        end
        chk("ovf_cnt2", 64'(ovf_cnt), 64'd2);
        chk("ovf_coal", 64'(coal_pend), 64'd1);
        chk("ovf_head", 64'(evt_vec), 64'h1);
        p0 = pops;
        for (int i = 0; i < 7; i++) step(rin, ALL, '0, 1'b1, 1'b0);
        chk("ovf_drain", 64'(pops - p0), 64'd5);

        // Full FIFO, pop and ch7 rise in the same cycle.
        step('0, ALL, '0, 1'b0, 1'b1);
        rin = '0;
        for (int i = 0; i < 4; i++) begin
            rin[i] = 1'b1;
            step(rin, ALL, '0, 1'b0, 1'b0);
        end
        rin[7] = 1'b1;
        step(rin, ALL, '0, 1'b1, 1'b0);
        chk("fullpop_ovf", 64'(ovf_cnt), 64'd0);
        chk("fullpop_coal", 64'(coal_pend), 64'd0);
        p0 = pops;
        for (int i = 0; i < 6; i++) step(rin, ALL, '0, 1'b1, 1'b0);
        chk("fullpop_drain", 64'(pops - p0), 64'd4);

        // Reset with three queued events.
        step('0, ALL, '0, 1'b0, 1'b1);
        step(32'h1, ALL, '0, 1'b0, 1'b0);
        step(32'h3, ALL, '0, 1'b0, 1'b0);
        step(32'h7, ALL, '0, 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(evt_valid), 64'd1);
        step(32'h7, ALL, '0, 1'b0, 1'b1);
        chk("mid_rst_valid", 64'(evt_valid), 64'd0);
        chk("mid_rst_ovf", 64'(ovf_cnt), 64'd0);
        step(32'h7, ALL, '0, 1'b0, 1'b0);
        chk("post_rst_tick", 64'(evt_tick), 64'd0);
        chk("post_rst_vec", 64'(evt_vec), 64'h7);
        for (int i = 0; i < 3; i++) step(32'h7, ALL, '0, 1'b1, 1'b0);

        // Randomised phases with varying consumer throughput and mode changes.
        rin = '0;
        rmask = ALL; rlvl = '0; rdy_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                rmask   = $urandom | $urandom;
                rlvl    = $urandom;
                rdy_pct = $urandom_range(5, 100);
            end
            rin = rin ^ ($urandom & $urandom & $urandom & $urandom);
            step(rin, rmask, rlvl, ($urandom_range(1, 100) <= rdy_pct), ($urandom_range(0, 999) == 0));
        end
        for (int i = 0; i < 20; i++) step(rin, '0, rlvl, 1'b1, 1'b0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
